polyphase_decimator: RTL and testbench
======================================

Name: polyphase_decimator

Overview:
- Decimating polyphase FIR: accepts RATE_CHANGE input samples per output sample and emits one filtered sample per RATE_CHANGE inputs.
- Sits on the receive side of the sample-rate chain, as the counterpart to the interpolating polyphase filter.
- Uses a single time-multiplexed MAC over a NUMBER_TAPS delay line.
- AXI-Stream data in/out; a separate AXI-Stream port loads coefficients.

Parameters:
- NUMBER_TAPS, 32, total filter taps; must be a multiple of RATE_CHANGE.
- DATA_IN_WIDTH, 16, signed input sample width.
- DATA_OUT_WIDTH, 16, signed output sample width.
- COEFFICIENT_WIDTH, 16, signed coefficient width.
- RATE_CHANGE, 8, decimation factor, ≥2.
- OUTPUT_SHIFT, 15, arithmetic right shift applied to the accumulator before output.

Ports:
- clock  in  1  single clock for all logic.
- reset  in  1  reset, synchronous, active-high.
- data_in_tdata  in  DATA_IN_WIDTH  input sample.
- data_in_tvalid  in  1  input valid.
- data_in_tlast  in  1  last sample of the frame.
- data_in_tready  out  1  input ready.
- data_out_tdata  out  DATA_OUT_WIDTH  decimated sample.
- data_out_tvalid  out  1  output valid.
- data_out_tlast  out  1  last output of the frame.
- data_out_tready  in  1  downstream ready.
- coefficients_in_tdata  in  COEFFICIENT_WIDTH  coefficient, h[0] first.
- coefficients_in_tvalid  in  1  coefficient valid.
- coefficients_in_tlast  in  1  final coefficient.
- coefficients_in_tready  out  1  coefficient ready.

Behaviour:
- Arithmetic
  - Accumulator width: DATA_IN_WIDTH + COEFFICIENT_WIDTH + clog2(NUMBER_TAPS), signed.
  - Delay line d[0..NUMBER_TAPS-1], with d[0] the newest sample. Each accepted or padded sample shifts the line by one.
  - y = (sum over k of h[k]*d[k]) >>> OUTPUT_SHIFT, truncated to the low DATA_OUT_WIDTH bits (wraps).
- Reset
  - State COLLECT, phase count 0, delay line zeroed, coefficient write index 0, coefficient RAM contents retained.
  - data_out_tvalid=0, data_out_tlast=0, data_out_tdata=0, data_in_tready=0 during reset.
- Coefficient load
  - coefficients_in_tready = (state==COLLECT).
  - On each handshake, write h[idx] and increment idx.
  - idx returns to 0 on tlast or after NUMBER_TAPS-1.
  - A coefficient handshake and a data handshake may occur in the same cycle.
- FSM
  - COLLECT: data_in_tready=1.
    - On handshake: shift the sample in and increment the phase count.
    - When the RATE_CHANGE-th sample is accepted, go to MAC. If tlast was on that sample, set the frame_end flag.
    - If tlast arrives at phase count <RATE_CHANGE-1, set frame_end and go to FLUSH.
  - FLUSH: data_in_tready=0.
    - Shift in one zero per cycle until the phase count reaches RATE_CHANGE, then go to MAC.
  - MAC: data_in_tready=0.
    - One tap per cycle over NUMBER_TAPS cycles, k=0..NUMBER_TAPS-1, then go to OUTPUT.
  - OUTPUT: data_out_tvalid=1; data and last are held stable until tready.
    - data_out_tlast = frame_end.
    - On handshake: go to COLLECT with phase count 0.
    - If frame_end was set, zero the delay line and clear frame_end in the same cycle.
- Latency: the RATE_CHANGE-th sample is accepted in cycle t → data_out_tvalid asserts at t+NUMBER_TAPS+1.
- Sustained throughput: one output per RATE_CHANGE+NUMBER_TAPS+1 cycles with tready held high.
- Backpressure: data_out_tready low only stalls OUTPUT. No input is accepted while an output is pending.
- Reset mid-MAC/FLUSH/OUTPUT: the partial result is discarded and no output is emitted. The next output needs RATE_CHANGE fresh samples.
- data_in_tvalid while not ready is ignored, and no state changes.

Optional Feature:
- Macro: POLYPHASE_DECIMATOR_SATURATE_EN.
- Defined: after the shift, values above the DATA_OUT_WIDTH range clamp to max positive (e.g. 32767), and values below clamp to min negative (-32768).
- Undefined: plain truncation/wrap as above.

Test Plan:
- Impulse response: N=16, R=4, OUTPUT_SHIFT=0, h[0]=1 and rest 0, input 1,2..8 → outputs 4, 8. Output tvalid first asserts 17 cycles after the 4th sample is accepted.
- Ramp-up: h all 1, input all 1s, 24 samples → outputs 4, 8, 12, 16, 16, 16.
- Short frame: h all 1, 6 ones with tlast on the 6th → outputs 4 then 6 with tlast=1. Next 4 ones → 4, confirming the delay line was cleared.
- Backpressure: hold data_out_tready=0 for 10 cycles in OUTPUT → tdata stable, data_in_tready=0 throughout, no lost samples, same results as the ramp-up test.
- Saturation: h all 32767, inputs 32767, OUTPUT_SHIFT=0.
  - With the macro → 32767.
  - Without the macro → low 16 bits of the exact sum.
- Reset mid-MAC: assert reset in MAC cycle 5 → no output. Coefficients are retained, so the impulse-response test passes without reload.

Source files
------------

// File: rtl/polyphase_decimator_if.sv
// AXI-Stream style channel used for sample input, sample output and coefficient loading.
interface polyphase_decimator_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tlast;
    logic             tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/polyphase_decimator.sv
// Decimating FIR, one time-multiplexed MAC; POLYPHASE_DECIMATOR_SATURATE_EN clamps the output instead of wrapping.
// Latency: valid asserts NUMBER_TAPS+1 cycles after the RATE_CHANGE-th input is accepted.
// Backpressure: inputs are refused outside COLLECT; data_out_tready low only holds OUTPUT.
module polyphase_decimator #(
    parameter int NUMBER_TAPS       = 32,
    parameter int DATA_IN_WIDTH     = 16,
    parameter int DATA_OUT_WIDTH    = 16,
    parameter int COEFFICIENT_WIDTH = 16,
    parameter int RATE_CHANGE       = 8,
    parameter int OUTPUT_SHIFT      = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    polyphase_decimator_if.slave  data_in,
    polyphase_decimator_if.master data_out,
    polyphase_decimator_if.slave  coefficients_in
);
    localparam int TAP_W   = $clog2(NUMBER_TAPS);
    localparam int PHASE_W = $clog2(RATE_CHANGE + 1);
    localparam int PROD_W  = DATA_IN_WIDTH + COEFFICIENT_WIDTH;
    localparam int ACC_W   = PROD_W + $clog2(NUMBER_TAPS);

    typedef enum logic [1:0] {COLLECT, FLUSH, MAC, OUTPUT} state_t;

    state_t                         r_state, w_state_next;
    logic [PHASE_W-1:0]             r_phase, w_phase_next;
    logic [TAP_W-1:0]               r_tap;
    logic [TAP_W-1:0]               r_coef_idx;
    logic                           r_frame_end;
    logic signed [DATA_IN_WIDTH-1:0]     r_delay [NUMBER_TAPS];
    logic signed [COEFFICIENT_WIDTH-1:0] r_coef  [NUMBER_TAPS];
    logic signed [ACC_W-1:0]        r_acc;
    logic signed [PROD_W-1:0]       w_product;
    logic signed [DATA_IN_WIDTH-1:0] w_shift_dat;
    logic [DATA_OUT_WIDTH-1:0]      w_out_dat;
    logic w_in_rdy, w_in_hs, w_coef_hs, w_out_vld, w_shift_in, w_clear_line;

    assign w_in_rdy  = (r_state == COLLECT) && !reset;
    assign w_in_hs   = w_in_rdy && data_in.tvalid;
    assign w_coef_hs = w_in_rdy && coefficients_in.tvalid;
    assign w_out_vld = (r_state == OUTPUT) && !reset;

    assign data_in.tready         = w_in_rdy;
    assign coefficients_in.tready = w_in_rdy;
    assign data_out.tvalid        = w_out_vld;
    assign data_out.tlast         = w_out_vld && r_frame_end;
    assign data_out.tdata         = w_out_vld ? w_out_dat : '0;

    assign w_product = r_coef[r_tap] * r_delay[r_tap];

`ifdef POLYPHASE_DECIMATOR_SATURATE_EN
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W - DATA_OUT_WIDTH + 1){1'b0}}, {(DATA_OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W - DATA_OUT_WIDTH + 1){1'b1}}, {(DATA_OUT_WIDTH - 1){1'b0}}};
    logic signed [ACC_W-1:0] w_shifted;

    assign w_shifted = r_acc >>> OUTPUT_SHIFT;

    always_comb begin
        w_out_dat = w_shifted[DATA_OUT_WIDTH-1:0];
        if (w_shifted > OUT_MAX) begin
            w_out_dat = OUT_MAX[DATA_OUT_WIDTH-1:0];
        end else if (w_shifted < OUT_MIN) begin
            w_out_dat = OUT_MIN[DATA_OUT_WIDTH-1:0];
        end
    end
`else
    assign w_out_dat = DATA_OUT_WIDTH'(r_acc >>> OUTPUT_SHIFT);
`endif

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_shift_in   = 1'b0;
        w_shift_dat  = '0;
        w_clear_line = 1'b0;
        case (r_state)
            COLLECT: begin
                if (w_in_hs) begin
                    w_shift_in   = 1'b1;
                    w_shift_dat  = data_in.tdata;
                    w_phase_next = r_phase + PHASE_W'(1);
                    if (r_phase == PHASE_W'(RATE_CHANGE - 1)) begin
                        w_state_next = MAC;
                    end else if (data_in.tlast) begin
                        w_state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // Zero-pad a short frame up to a full decimation phase.
                w_shift_in   = 1'b1;
                w_phase_next = r_phase + PHASE_W'(1);
                if (r_phase == PHASE_W'(RATE_CHANGE - 1)) begin
                    w_state_next = MAC;
                end
            end
            MAC: begin
                if (r_tap == TAP_W'(NUMBER_TAPS - 1)) begin
                    w_state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                if (data_out.tready) begin
                    w_state_next = COLLECT;
                    w_phase_next = '0;
                    w_clear_line = r_frame_end;
                end
            end
            default: w_state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= COLLECT;
            r_phase     <= '0;
            r_tap       <= '0;
            r_acc       <= '0;
            r_frame_end <= 1'b0;
            r_coef_idx  <= '0;
        end else begin
            r_state <= w_state_next;
            r_phase <= w_phase_next;
            if (w_clear_line) begin
                r_frame_end <= 1'b0;
            end else if (w_in_hs && data_in.tlast) begin
                r_frame_end <= 1'b1;
            end
            if (r_state == MAC) begin
                r_tap <= (r_tap == TAP_W'(NUMBER_TAPS - 1)) ? '0 : r_tap + TAP_W'(1);
                if (r_tap == '0) begin
                    r_acc <= {{(ACC_W - PROD_W){w_product[PROD_W-1]}}, w_product};
                end else begin
                    r_acc <= r_acc + {{(ACC_W - PROD_W){w_product[PROD_W-1]}}, w_product};
                end
            end else begin
                r_tap <= '0;
            end
            if (w_coef_hs) begin
                if (coefficients_in.tlast || r_coef_idx == TAP_W'(NUMBER_TAPS - 1)) begin
                    r_coef_idx <= '0;
                end else begin
                    r_coef_idx <= r_coef_idx + TAP_W'(1);
                end
            end
        end
    end

    // Coefficient storage deliberately survives reset.
    always_ff @(posedge clock) begin
        if (w_coef_hs) begin
            r_coef[r_coef_idx] <= coefficients_in.tdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || w_clear_line) begin
            for (int i = 0; i < NUMBER_TAPS; i++) begin
                r_delay[i] <= '0;
            end
        end else if (w_shift_in) begin
            r_delay[0] <= w_shift_dat;
            for (int i = 1; i < NUMBER_TAPS; i++) begin
                r_delay[i] <= r_delay[i-1];
            end
        end
    end
endmodule

// File: tb/tb_polyphase_decimator.sv
// Bench for polyphase_decimator (16 taps, decimate by 4, no output shift): vector table,
// scoreboard of expected outputs, plus backpressure and reset-during-MAC sequences.
module tb_polyphase_decimator;
    localparam int N = 16;
    localparam int R = 4;
    localparam int W = 16;

    typedef struct {
        int              coef_mode;
        int              samp_mode;
        int              n_samp;
        int              last_at;
        bit              reload;
        bit              bp;
        int              n_out;
        logic [5:0][15:0] exp_dat;
        logic [5:0]       exp_last;
    } vec_t;

    typedef struct {
        logic [15:0] dat;
        logic        last;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic out_rdy = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   first_vld_cyc = -1;
    bit   bp_req = 1'b0;
    int   bp_left = 0;
    exp_t exp_q[$];
    vec_t vecs[6];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    polyphase_decimator_if #(.WIDTH(W)) data_in_if();
    polyphase_decimator_if #(.WIDTH(W)) data_out_if();
    polyphase_decimator_if #(.WIDTH(W)) coef_if();

    assign data_out_if.tready = out_rdy;

    polyphase_decimator #(
        .NUMBER_TAPS(N), .DATA_IN_WIDTH(W), .DATA_OUT_WIDTH(W),
        .COEFFICIENT_WIDTH(W), .RATE_CHANGE(R), .OUTPUT_SHIFT(0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .data_in(data_in_if),
        .data_out(data_out_if),
        .coefficients_in(coef_if)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        if (data_out_if.tvalid === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
    endtask

    function automatic logic [15:0] samp(input int mode, input int j);
        case (mode)
            0:       return 16'(j + 1);
            1:       return 16'd1;
            default: return 16'd32767;
        endcase
    endfunction

    function automatic logic [15:0] coef(input int mode, input int k);
        case (mode)
            0:       return (k == 0) ? 16'd1 : 16'd0;
            1:       return 16'd1;
            default: return 16'd32767;
        endcase
    endfunction

    function automatic vec_t mk(input int cm, input int sm, input int n, input int la,
                                input bit rl, input bit bp, input int no);
        vec_t v;
        v.coef_mode = cm; v.samp_mode = sm; v.n_samp = n; v.last_at = la;
        v.reload = rl; v.bp = bp; v.n_out = no; v.exp_dat = '0; v.exp_last = '0;
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        check("rst_in_rdy", data_in_if.tready, 0);
        check("rst_coef_rdy", coef_if.tready, 0);
        check("rst_out_vld", data_out_if.tvalid, 0);
        check("rst_out_last", data_out_if.tlast, 0);
        check("rst_out_dat", data_out_if.tdata, 0);
        reset = 1'b0;
        tick();
        check("post_rst_in_rdy", data_in_if.tready, 1);
    endtask

    task automatic load_coefs(input int mode);
        int guard;
        for (int k = 0; k < N; k++) begin
            coef_if.tdata = coef(mode, k);
            coef_if.tlast = (k == N - 1);
            coef_if.tvalid = 1'b1;
            guard = 0;
            while (coef_if.tready !== 1'b1 && guard < 300) begin tick(); guard++; end
            if (guard >= 300) check("coef_accept_timeout", guard, 0);
            tick();
        end
        coef_if.tvalid = 1'b0;
        coef_if.tlast = 1'b0;
    endtask

    task automatic send_sample(input logic [15:0] d, input logic l, output int acc_cyc);
        int guard = 0;
        data_in_if.tdata = d;
        data_in_if.tlast = l;
        data_in_if.tvalid = 1'b1;
        while (data_in_if.tready !== 1'b1 && guard < 300) begin tick(); guard++; end
        if (guard >= 300) check("in_accept_timeout", guard, 0);
        acc_cyc = cyc;
        tick();
        data_in_if.tvalid = 1'b0;
        data_in_if.tlast = 1'b0;
    endtask

    task automatic run_vector(input int i);
        vec_t v;
        exp_t e;
        int acc_cyc, rth_cyc, guard;
        v = vecs[i];
        exp_q.delete();
        do_reset();
        if (v.reload) load_coefs(v.coef_mode);
        for (int j = 0; j < v.n_out; j++) begin
            e.dat = v.exp_dat[j];
            e.last = v.exp_last[j];
            exp_q.push_back(e);
        end
        bp_req = v.bp;
        first_vld_cyc = -1;
        rth_cyc = -1;
        for (int j = 0; j < v.n_samp; j++) begin
            send_sample(samp(v.samp_mode, j), (j == v.last_at), acc_cyc);
            if (j == R - 1) rth_cyc = acc_cyc;
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin tick(); guard++; end
        check($sformatf("drain_v%0d", i), exp_q.size(), 0);
        check($sformatf("latency_v%0d", i), first_vld_cyc - rth_cyc, N + 1);
        tick();
    endtask

    task automatic reset_mid_mac();
        int acc_cyc, cnt;
        exp_q.delete();
        do_reset();
        load_coefs(0);
        for (int j = 0; j < R; j++) send_sample(samp(0, j), 1'b0, acc_cyc);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        cnt = 0;
        repeat (40) begin
            tick();
            if (data_out_if.tvalid === 1'b1) cnt++;
        end
        check("rst_mac_no_output", cnt, 0);
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && data_out_if.tvalid === 1'b1) begin
                if (bp_req) begin bp_req = 1'b0; bp_left = 10; end
                if (exp_q.size() == 0) begin
                    out_rdy = 1'b1;
                    check("unexpected_output_q", exp_q.size(), 1);
                end else if (bp_left > 0) begin
                    out_rdy = 1'b0;
                    check("bp_hold_dat", data_out_if.tdata, exp_q[0].dat);
                    check("bp_in_rdy", data_in_if.tready, 0);
                    bp_left--;
                end else begin
                    out_rdy = 1'b1;
                    e = exp_q.pop_front();
                    check("out_dat", data_out_if.tdata, e.dat);
                    check("out_last", data_out_if.tlast, e.last);
                end
            end
        end
    endtask

    task automatic main_seq();
        data_in_if.tdata = '0; data_in_if.tvalid = 1'b0; data_in_if.tlast = 1'b0;
        coef_if.tdata = '0; coef_if.tvalid = 1'b0; coef_if.tlast = 1'b0;

        vecs[0] = mk(0, 0, 8, -1, 1'b1, 1'b0, 2);
        vecs[0].exp_dat[0] = 16'd4; vecs[0].exp_dat[1] = 16'd8;
        vecs[1] = mk(1, 1, 24, -1, 1'b1, 1'b0, 6);
        vecs[1].exp_dat[0] = 16'd4;  vecs[1].exp_dat[1] = 16'd8;  vecs[1].exp_dat[2] = 16'd12;
        vecs[1].exp_dat[3] = 16'd16; vecs[1].exp_dat[4] = 16'd16; vecs[1].exp_dat[5] = 16'd16;
        vecs[2] = mk(1, 1, 10, 5, 1'b1, 1'b0, 3);
        vecs[2].exp_dat[0] = 16'd4; vecs[2].exp_dat[1] = 16'd6; vecs[2].exp_dat[2] = 16'd4;
        vecs[2].exp_last[1] = 1'b1;
        vecs[3] = mk(2, 2, 16, -1, 1'b1, 1'b0, 4);
`ifdef POLYPHASE_DECIMATOR_SATURATE_EN
        for (int j = 0; j < 4; j++) vecs[3].exp_dat[j] = 16'd32767;
`else
        // Exact sums are k*4*32767^2; their low 16 bits are 4, 8, 12, 16.
        vecs[3].exp_dat[0] = 16'd4;  vecs[3].exp_dat[1] = 16'd8;
        vecs[3].exp_dat[2] = 16'd12; vecs[3].exp_dat[3] = 16'd16;
`endif
        vecs[4] = vecs[1];
        vecs[4].bp = 1'b1;
        vecs[5] = vecs[0];
        vecs[5].reload = 1'b0;

        for (int i = 0; i < 5; i++) run_vector(i);
        reset_mid_mac();
        run_vector(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    initial begin
        fork
            monitor_loop();
            main_seq();
        join
    end
endmodule
